// File: rtl/issue_scoreboard.sv
// issue_scoreboard: decode-side issue controller for the RV64 pipeline.
// Keeps a pending-write counter per architectural register. It gates issue
// on RAW hazards, WAW counter saturation and unresolved control transfers,
// and sequences fetch hold and flush around branches and jumps.
//
// Ports:
//   CLK, RESET_N        core clock, asynchronous active-low reset
//   DE_V, DE_IR         valid instruction in decode and its encoding
//   EXE_BR_RESOLVED     one-cycle pulse when a branch/JAL/JALR resolves
//   EXE_BR_TAKEN        qualifies EXE_BR_RESOLVED, 1 = redirect
//   WB_V, WB_REG_WEN,
//   WB_DR               writeback valid, register write enable, destination
//   STALL               hold decode and fetch (combinational)
//   ISSUE               decode instruction accepted this cycle (combinational)
//   FE_HOLD             fetch must not advance (combinational)
//   FLUSH               squash fetch/decode contents (registered)
//   BUSY_MASK           per-register "has pending write" flags (registered)
//   STATE               controller state: 0 RUN, 1 BR_WAIT, 2 FLUSH
module issue_scoreboard #(
    parameter int unsigned CNT_W = 2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        DE_V,
    input  logic [31:0] DE_IR,
    input  logic        EXE_BR_RESOLVED,
    input  logic        EXE_BR_TAKEN,
    input  logic        WB_V,
    input  logic        WB_REG_WEN,
    input  logic [4:0]  WB_DR,
    output logic        STALL,
    output logic        ISSUE,
    output logic        FE_HOLD,
    output logic        FLUSH,
    output logic [31:0] BUSY_MASK,
    output logic [1:0]  STATE
);

    localparam int unsigned NREG = 32;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_BR_WAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic [NREG-1:0]  busy_q;
    logic [NREG-1:0]  busy_d;
    logic             flush_q;

    logic [4:0] opc;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       writes_rd;
    logic       reads_rs1;
    logic       reads_rs2;
    logic       is_ctrl;
    logic       raw;
    logic       waw_sat;
    logic [NREG-1:0] inc_vec;
    logic [NREG-1:0] dec_vec;

    // Funct fields and the compressed-length bits do not affect issue.
    logic unused_ir;
    assign unused_ir = ^{DE_IR[31:25], DE_IR[14:12], DE_IR[1:0]};

    assign opc = DE_IR[6:2];
    assign rd  = DE_IR[11:7];
    assign rs1 = DE_IR[19:15];
    assign rs2 = DE_IR[24:20];

    // Opcode class decode: which register fields are live, and control transfers.
    always_comb begin
        writes_rd = 1'b0;
        reads_rs1 = 1'b0;
        reads_rs2 = 1'b0;
        is_ctrl   = 1'b0;
        case (opc)
            5'b00000, 5'b00100, 5'b00110: begin
                writes_rd = 1'b1;
                reads_rs1 = 1'b1;
            end
            5'b01000: begin
                reads_rs1 = 1'b1;
                reads_rs2 = 1'b1;
            end
            5'b01100, 5'b01110: begin
                writes_rd = 1'b1;
                reads_rs1 = 1'b1;
                reads_rs2 = 1'b1;
            end
            5'b01101, 5'b00101: begin
                writes_rd = 1'b1;
            end
            5'b11000: begin
                reads_rs1 = 1'b1;
                reads_rs2 = 1'b1;
                is_ctrl   = 1'b1;
            end
            5'b11001: begin
                writes_rd = 1'b1;
                reads_rs1 = 1'b1;
                is_ctrl   = 1'b1;
            end
            5'b11011: begin
                writes_rd = 1'b1;
                is_ctrl   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Hazards look only at registered counts; a same-cycle writeback does not bypass.
    assign raw = (reads_rs1 && (rs1 != 5'd0) && (cnt_q[rs1] != '0))
              || (reads_rs2 && (rs2 != 5'd0) && (cnt_q[rs2] != '0));
    assign waw_sat = writes_rd && (rd != 5'd0) && (cnt_q[rd] == CNT_MAX);

    // Next-state and combinational issue outputs.
    always_comb begin
        state_d = state_q;
        STALL   = (state_q != ST_RUN) || (DE_V && (raw || waw_sat));
        ISSUE   = DE_V && !STALL;
        FE_HOLD = (state_q == ST_BR_WAIT) || ((state_q == ST_RUN) && DE_V && STALL);
        case (state_q)
            ST_RUN: begin
                if (ISSUE && is_ctrl) begin
                    state_d = ST_BR_WAIT;
                end
            end
            ST_BR_WAIT: begin
                if (EXE_BR_RESOLVED) begin
                    state_d = EXE_BR_TAKEN ? ST_FLUSH : ST_RUN;
                end
            end
            ST_FLUSH: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // One-hot increment/decrement requests; x0 is never tracked.
    assign inc_vec = (ISSUE && writes_rd && (rd != 5'd0)) ? (NREG'(1) << rd) : '0;
    assign dec_vec = (WB_V && WB_REG_WEN && (WB_DR != 5'd0)) ? (NREG'(1) << WB_DR) : '0;

    // Per-register counter update; inc+dec cancels, decrement floors at zero.
    always_comb begin
        busy_d = '0;
        for (int r = 0; r < int'(NREG); r++) begin
            cnt_d[r] = cnt_q[r];
            if (inc_vec[r] && !dec_vec[r]) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (dec_vec[r] && !inc_vec[r] && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
            busy_d[r] = (cnt_d[r] != '0);
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_RUN;
            flush_q <= 1'b0;
            busy_q  <= '0;
            for (int r = 0; r < int'(NREG); r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            state_q <= state_d;
            flush_q <= (state_d == ST_FLUSH);
            busy_q  <= busy_d;
            for (int r = 0; r < int'(NREG); r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign FLUSH     = flush_q;
    assign BUSY_MASK = busy_q;
    assign STATE     = state_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed scenarios plus a
// randomized run compared against a counter/state reference model.
module tb_issue_scoreboard;

    localparam int unsigned CNT_W = 2;
    localparam int MAXC = (1 << CNT_W) - 1;

    logic        CLK;
    logic        RESET_N;
    logic        DE_V;
    logic [31:0] DE_IR;
    logic        EXE_BR_RESOLVED;
    logic        EXE_BR_TAKEN;
    logic        WB_V;
    logic        WB_REG_WEN;
    logic [4:0]  WB_DR;
    logic        STALL;
    logic        ISSUE;
    logic        FE_HOLD;
    logic        FLUSH;
    logic [31:0] BUSY_MASK;
    logic [1:0]  STATE;

    int checks = 0;
    int failures = 0;

    // Reference model: pending-write count per register and controller state.
    int mcnt [32];
    int mstate;
    bit mflush;

    issue_scoreboard #(.CNT_W(CNT_W)) dut (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .DE_V(DE_V),
        .DE_IR(DE_IR),
        .EXE_BR_RESOLVED(EXE_BR_RESOLVED),
        .EXE_BR_TAKEN(EXE_BR_TAKEN),
        .WB_V(WB_V),
        .WB_REG_WEN(WB_REG_WEN),
        .WB_DR(WB_DR),
        .STALL(STALL),
        .ISSUE(ISSUE),
        .FE_HOLD(FE_HOLD),
        .FLUSH(FLUSH),
        .BUSY_MASK(BUSY_MASK),
        .STATE(STATE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Instruction encoders.
    function automatic logic [31:0] enc_addi(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd1, rs1, 3'b000, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] enc_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_beq(input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b000, 5'd0, 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_jal(input logic [4:0] rd);
        return {20'd0, rd, 7'b1101111};
    endfunction

    // Model: opcode class membership straight from the opcode tables.
    function automatic bit m_writes(input logic [4:0] op);
        return op inside {5'b00000, 5'b00100, 5'b00110, 5'b01100, 5'b01110,
                          5'b01101, 5'b00101, 5'b11011, 5'b11001};
    endfunction
    function automatic bit m_rs1(input logic [4:0] op);
        return op inside {5'b00000, 5'b00100, 5'b00110, 5'b01000, 5'b01100,
                          5'b01110, 5'b11000, 5'b11001};
    endfunction
    function automatic bit m_rs2(input logic [4:0] op);
        return op inside {5'b01000, 5'b01100, 5'b01110, 5'b11000};
    endfunction
    function automatic bit m_ctrl(input logic [4:0] op);
        return op inside {5'b11000, 5'b11001, 5'b11011};
    endfunction

    function automatic logic [31:0] m_mask();
        logic [31:0] m;
        m = '0;
        for (int r = 0; r < 32; r++) m[r] = (mcnt[r] > 0);
        return m;
    endfunction

    // Model of the combinational outputs for the current inputs.
    task automatic model_comb(output bit stall, output bit issue, output bit hold);
        int s1, s2, d;
        bit raw, waw;
        s1 = int'(DE_IR[19:15]);
        s2 = int'(DE_IR[24:20]);
        d  = int'(DE_IR[11:7]);
        raw = (m_rs1(DE_IR[6:2]) && s1 != 0 && mcnt[s1] > 0) ||
              (m_rs2(DE_IR[6:2]) && s2 != 0 && mcnt[s2] > 0);
        waw = m_writes(DE_IR[6:2]) && d != 0 && mcnt[d] == MAXC;
        stall = (mstate != 0) || (DE_V && (raw || waw));
        issue = DE_V && !stall;
        hold  = (mstate == 1) || (mstate == 0 && DE_V && stall);
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) mcnt[r] = 0;
        mstate = 0;
        mflush = 1'b0;
    endtask

    task automatic set_in(input bit dv, input logic [31:0] ir, input bit res, input bit tk,
                          input bit wbv, input bit wen, input logic [4:0] dr);
        DE_V = dv;
        DE_IR = ir;
        EXE_BR_RESOLVED = res;
        EXE_BR_TAKEN = tk;
        WB_V = wbv;
        WB_REG_WEN = wen;
        WB_DR = dr;
        #1;
    endtask

    // Advance one clock, updating the model from the inputs held across the edge.
    task automatic tick();
        bit st, is, ho;
        int ncnt [32];
        int nst;
        int d, w;
        model_comb(st, is, ho);
        d = int'(DE_IR[11:7]);
        w = int'(WB_DR);
        for (int r = 0; r < 32; r++) begin
            bit inc, dec;
            inc = is && m_writes(DE_IR[6:2]) && d == r && r != 0;
            dec = WB_V && WB_REG_WEN && w == r && r != 0;
            ncnt[r] = mcnt[r];
            if (inc && !dec) ncnt[r] = mcnt[r] + 1;
            else if (dec && !inc && mcnt[r] > 0) ncnt[r] = mcnt[r] - 1;
        end
        nst = mstate;
        if (mstate == 0) begin
            if (is && m_ctrl(DE_IR[6:2])) nst = 1;
        end else if (mstate == 1) begin
            if (EXE_BR_RESOLVED) nst = EXE_BR_TAKEN ? 2 : 0;
        end else begin
            nst = 0;
        end
        @(posedge CLK);
        for (int r = 0; r < 32; r++) mcnt[r] = ncnt[r];
        mstate = nst;
        mflush = (nst == 2);
        #1;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        set_in(0, '0, 0, 0, 0, 0, 5'd0);
        model_reset();
        repeat (2) @(posedge CLK);
        #2;
        checks++;
        if (STATE !== 2'd0 || BUSY_MASK !== 32'd0 || STALL !== 1'b0 || FLUSH !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: state=%0d busy=%h stall=%b flush=%b want 0/0/0/0",
                     STATE, BUSY_MASK, STALL, FLUSH);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
        tick();
        checks++;
        if (STATE !== 2'd0 || BUSY_MASK !== 32'd0 || STALL !== 1'b0 || FLUSH !== 1'b0 ||
            ISSUE !== 1'b0 || FE_HOLD !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: state=%0d busy=%h stall=%b flush=%b issue=%b hold=%b want all 0",
                     STATE, BUSY_MASK, STALL, FLUSH, ISSUE, FE_HOLD);
        end
    endtask

    task automatic test_raw();
        set_in(1, enc_addi(5'd5, 5'd0), 0, 0, 0, 0, 5'd0);
        checks++;
        if (ISSUE !== 1'b1 || STALL !== 1'b0) begin
            failures++;
            $display("FAIL raw_first_issue: issue=%b stall=%b want 1/0", ISSUE, STALL);
        end
        tick();
        for (int c = 1; c <= 3; c++) begin
            set_in(1, enc_add(5'd6, 5'd5, 5'd5), 0, 0, c == 3, c == 3, 5'd5);
            checks++;
            if (STALL !== 1'b1 || ISSUE !== 1'b0 || BUSY_MASK[5] !== 1'b1 || FE_HOLD !== 1'b1) begin
                failures++;
                $display("FAIL raw_stall_t%0d: stall=%b issue=%b busy5=%b hold=%b want 1/0/1/1",
                         c, STALL, ISSUE, BUSY_MASK[5], FE_HOLD);
            end
            tick();
        end
        set_in(1, enc_add(5'd6, 5'd5, 5'd5), 0, 0, 0, 0, 5'd0);
        checks++;
        if (STALL !== 1'b0 || ISSUE !== 1'b1 || BUSY_MASK[5] !== 1'b0) begin
            failures++;
            $display("FAIL raw_release: stall=%b issue=%b busy5=%b want 0/1/0", STALL, ISSUE, BUSY_MASK[5]);
        end
        tick();
        set_in(0, '0, 0, 0, 1, 1, 5'd6);
        tick();
        checks++;
        if (BUSY_MASK !== 32'd0) begin
            failures++;
            $display("FAIL raw_drain: busy=%h want 0", BUSY_MASK);
        end
    endtask

    task automatic test_inc_dec();
        set_in(1, enc_addi(5'd7, 5'd0), 0, 0, 0, 0, 5'd0);
        tick();
        set_in(1, enc_addi(5'd7, 5'd0), 0, 0, 1, 1, 5'd7);
        checks++;
        if (ISSUE !== 1'b1) begin
            failures++;
            $display("FAIL incdec_issue: issue=%b want 1", ISSUE);
        end
        tick();
        checks++;
        if (BUSY_MASK[7] !== 1'b1) begin
            failures++;
            $display("FAIL incdec_busy: busy7=%b want 1", BUSY_MASK[7]);
        end
        set_in(0, '0, 0, 0, 1, 1, 5'd7);
        tick();
        checks++;
        if (BUSY_MASK[7] !== 1'b0) begin
            failures++;
            $display("FAIL incdec_count1: busy7=%b want 0 after one wb", BUSY_MASK[7]);
        end
    endtask

    task automatic test_waw_saturation();
        for (int k = 0; k < MAXC; k++) begin
            set_in(1, enc_addi(5'd9, 5'd0), 0, 0, 0, 0, 5'd0);
            checks++;
            if (ISSUE !== 1'b1) begin
                failures++;
                $display("FAIL waw_issue%0d: issue=%b want 1", k, ISSUE);
            end
            tick();
        end
        for (int c = 0; c < 2; c++) begin
            set_in(1, enc_addi(5'd9, 5'd0), 0, 0, c == 1, c == 1, 5'd9);
            checks++;
            if (STALL !== 1'b1 || ISSUE !== 1'b0) begin
                failures++;
                $display("FAIL waw_stall%0d: stall=%b issue=%b want 1/0", c, STALL, ISSUE);
            end
            tick();
        end
        set_in(1, enc_addi(5'd9, 5'd0), 0, 0, 0, 0, 5'd0);
        checks++;
        if (ISSUE !== 1'b1) begin
            failures++;
            $display("FAIL waw_release: issue=%b want 1", ISSUE);
        end
        tick();
        for (int k = 0; k < MAXC; k++) begin
            set_in(0, '0, 0, 0, 1, 1, 5'd9);
            tick();
        end
        checks++;
        if (BUSY_MASK !== 32'd0) begin
            failures++;
            $display("FAIL waw_drain: busy=%h want 0", BUSY_MASK);
        end
    endtask

    task automatic test_branch_not_taken();
        set_in(1, enc_beq(5'd0, 5'd0), 0, 0, 0, 0, 5'd0);
        checks++;
        if (ISSUE !== 1'b1) begin
            failures++;
            $display("FAIL bnt_issue: issue=%b want 1", ISSUE);
        end
        tick();
        for (int c = 1; c <= 3; c++) begin
            set_in(1, enc_addi(5'd3, 5'd0), c == 3, 0, 0, 0, 5'd0);
            checks++;
            if (STATE !== 2'd1 || STALL !== 1'b1 || FE_HOLD !== 1'b1 || ISSUE !== 1'b0 || FLUSH !== 1'b0) begin
                failures++;
                $display("FAIL bnt_wait_t%0d: state=%0d stall=%b hold=%b issue=%b flush=%b want 1/1/1/0/0",
                         c, STATE, STALL, FE_HOLD, ISSUE, FLUSH);
            end
            tick();
        end
        set_in(1, enc_addi(5'd0, 5'd0), 0, 0, 0, 0, 5'd0);
        checks++;
        if (STATE !== 2'd0 || FLUSH !== 1'b0 || ISSUE !== 1'b1) begin
            failures++;
            $display("FAIL bnt_resume: state=%0d flush=%b issue=%b want 0/0/1", STATE, FLUSH, ISSUE);
        end
        tick();
    endtask

    task automatic test_jal_taken();
        set_in(1, enc_jal(5'd1), 0, 0, 0, 0, 5'd0);
        tick();
        set_in(0, '0, 0, 0, 0, 0, 5'd0);
        checks++;
        if (STATE !== 2'd1 || BUSY_MASK[1] !== 1'b1) begin
            failures++;
            $display("FAIL jal_wait: state=%0d busy1=%b want 1/1", STATE, BUSY_MASK[1]);
        end
        tick();
        set_in(1, enc_addi(5'd4, 5'd0), 1, 1, 0, 0, 5'd0);
        checks++;
        if (STALL !== 1'b1 || FLUSH !== 1'b0) begin
            failures++;
            $display("FAIL jal_resolve_cycle: stall=%b flush=%b want 1/0", STALL, FLUSH);
        end
        tick();
        set_in(1, enc_addi(5'd4, 5'd0), 0, 0, 0, 0, 5'd0);
        checks++;
        if (FLUSH !== 1'b1 || STATE !== 2'd2 || STALL !== 1'b1 || FE_HOLD !== 1'b0 || ISSUE !== 1'b0) begin
            failures++;
            $display("FAIL jal_flush: flush=%b state=%0d stall=%b hold=%b issue=%b want 1/2/1/0/0",
                     FLUSH, STATE, STALL, FE_HOLD, ISSUE);
        end
        tick();
        set_in(0, '0, 0, 0, 0, 0, 5'd0);
        checks++;
        if (STATE !== 2'd0 || FLUSH !== 1'b0 || BUSY_MASK[1] !== 1'b1) begin
            failures++;
            $display("FAIL jal_after: state=%0d flush=%b busy1=%b want 0/0/1", STATE, FLUSH, BUSY_MASK[1]);
        end
        set_in(0, '0, 0, 0, 1, 1, 5'd1);
        tick();
        checks++;
        if (BUSY_MASK !== 32'd0) begin
            failures++;
            $display("FAIL jal_wb: busy=%h want 0", BUSY_MASK);
        end
    endtask

    task automatic test_reset_mid_branch();
        set_in(1, enc_jal(5'd2), 0, 0, 0, 0, 5'd0);
        tick();
        set_in(0, '0, 0, 0, 0, 0, 5'd0);
        #2;
        RESET_N = 1'b0;
        #1;
        model_reset();
        checks++;
        if (STATE !== 2'd0 || BUSY_MASK !== 32'd0 || STALL !== 1'b0 || FLUSH !== 1'b0 || FE_HOLD !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: state=%0d busy=%h stall=%b flush=%b hold=%b want all 0",
                     STATE, BUSY_MASK, STALL, FLUSH, FE_HOLD);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_random();
        logic [4:0] ops [12];
        logic [31:0] ir;
        bit e_st, e_is, e_ho;
        bit res;
        ops = '{5'b00000, 5'b00100, 5'b00110, 5'b01000, 5'b01100, 5'b01110,
                5'b01101, 5'b00101, 5'b11011, 5'b11001, 5'b11000, 5'b11100};
        for (int c = 0; c < 600; c++) begin
            ir = $urandom;
            ir[1:0]   = 2'b11;
            ir[6:2]   = ops[$urandom_range(0, 11)];
            ir[11:7]  = 5'($urandom_range(0, 7));
            ir[19:15] = 5'($urandom_range(0, 7));
            ir[24:20] = 5'($urandom_range(0, 7));
            res = (mstate == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
            set_in($urandom_range(0, 3) != 0, ir, res, $urandom_range(0, 1) == 1,
                   $urandom_range(0, 2) != 0, $urandom_range(0, 9) != 0, 5'($urandom_range(0, 7)));
            model_comb(e_st, e_is, e_ho);
            checks++;
            if (STALL !== e_st || ISSUE !== e_is || FE_HOLD !== e_ho) begin
                failures++;
                $display("FAIL rand_comb c%0d: stall/issue/hold=%b%b%b want %b%b%b",
                         c, STALL, ISSUE, FE_HOLD, e_st, e_is, e_ho);
            end
            tick();
            checks++;
            if (BUSY_MASK !== m_mask() || STATE !== 2'(mstate) || FLUSH !== mflush) begin
                failures++;
                $display("FAIL rand_reg c%0d: busy=%h state=%0d flush=%b want %h %0d %b",
                         c, BUSY_MASK, STATE, FLUSH, m_mask(), mstate, mflush);
            end
        end
    endtask

    initial begin
        test_reset();
        test_raw();
        test_inc_dec();
        test_waw_saturation();
        test_branch_not_taken();
        test_jal_taken();
        test_reset_mid_branch();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
